// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master
//   Turns single commands (read/write, address, data, size) into single AHB-Lite
//   transfers and reports each completion with a one-cycle response pulse.
//   Only one transfer is ever outstanding. Every output is driven from a register.
//
// Optional feature (macro AHB_MST_TIMEOUT_EN):
//   A transfer is abandoned with an error response after TIMEOUT_CYCLES
//   consecutive HREADY=0 cycles in the address or data phase. Without the macro
//   the master waits on HREADY indefinitely.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE and RESP)
//   cmd_write/addr/wdata/size command fields (size uses HSIZE encoding)
//   rsp_valid/rdata/err      one-cycle completion pulse, read data, error flag
//   HADDR..HWDATA            AHB-Lite master outputs
//   HRDATA, HREADY, HRESP    AHB-Lite master inputs
module ahb_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [2:0]            cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   haddr_reg, haddr_next;
    logic [1:0]              htrans_reg, htrans_next;
    logic                    hwrite_reg, hwrite_next;
    logic [2:0]              hsize_reg, hsize_next;
    logic [DATA_WIDTH-1:0]   hwdata_reg, hwdata_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    cmd_ready_reg, cmd_ready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic                    cmd_bad;
    logic                    timeout_hit;

    // Sizes above a word, or addresses not aligned to the size, never reach the bus.
    always_comb begin
        cmd_bad = 1'b0;
        if (cmd_size > 3'd2)
            cmd_bad = 1'b1;
        else if (cmd_size == 3'd1 && cmd_addr[0])
            cmd_bad = 1'b1;
        else if (cmd_size == 3'd2 && (cmd_addr[1:0] != 2'b00))
            cmd_bad = 1'b1;
    end

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    // Fires on the edge that ends the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign timeout_hit = !HREADY && (state_reg == ADDR || state_reg == DATA)
                         && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_next = '0;
        if (state_next == state_reg && (state_reg == ADDR || state_reg == DATA) && !HREADY)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        haddr_next     = haddr_reg;
        htrans_next    = HTRANS_IDLE;
        hwrite_next    = hwrite_reg;
        hsize_next     = hsize_reg;
        hwdata_next    = hwdata_reg;
        wdata_next     = wdata_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE, RESP: begin
                state_next = IDLE;
                if (cmd_valid && cmd_ready_reg) begin
                    if (cmd_bad) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next  = ADDR;
                        haddr_next  = cmd_addr;
                        hwrite_next = cmd_write;
                        hsize_next  = cmd_size;
                        wdata_next  = cmd_wdata;
                        htrans_next = HTRANS_NONSEQ;
                    end
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_next  = DATA;
                    hwdata_next = wdata_reg;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    htrans_next = HTRANS_NONSEQ;
                end
            end
            DATA: begin
                if (HREADY) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = HRESP;
                    rsp_rdata_next = hwrite_reg ? '0 : HRDATA;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        // Ready is registered, so it is derived from where the FSM is going.
        cmd_ready_next = (state_next == IDLE) || (state_next == RESP);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= IDLE;
            haddr_reg     <= '0;
            htrans_reg    <= HTRANS_IDLE;
            hwrite_reg    <= 1'b0;
            hsize_reg     <= 3'd0;
            hwdata_reg    <= '0;
            wdata_reg     <= '0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            haddr_reg     <= haddr_next;
            htrans_reg    <= htrans_next;
            hwrite_reg    <= hwrite_next;
            hsize_reg     <= hsize_next;
            hwdata_reg    <= hwdata_next;
            wdata_reg     <= wdata_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign HADDR     = haddr_reg;
    assign HTRANS    = htrans_reg;
    assign HWRITE    = hwrite_reg;
    assign HSIZE     = hsize_reg;
    assign HWDATA    = hwdata_reg;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed commands, a small AHB slave with
// configurable wait states / error responses, and a scoreboard monitor that
// checks each response pulse (data, error flag and arrival time).
module tb_ahb_lite_cmd_master;

    localparam int PERIOD = 10;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #(PERIOD/2) HCLK = ~HCLK;

    ahb_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct { logic [31:0] rdata; logic err; time t; } exp_t;
    typedef struct { logic [31:0] addr; logic write; logic [2:0] size; logic [31:0] wdata; } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;

    // slave configuration
    int          cfg_await = 0;
    int          cfg_dwait = 0;
    logic        cfg_err   = 1'b0;
    logic        cfg_noise = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    // ---------------- response monitor ----------------
    always @(negedge HCLK) begin
        if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%0d at %0t, required no response",
                         rsp_rdata, rsp_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || $time != e.t) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%0d t=%0t, required rdata=%h err=%0d t=%0t",
                             rsp_rdata, rsp_err, $time, e.rdata, e.err, e.t);
                end else
                    $display("rsp ok: rdata=%h err=%0d t=%0t", rsp_rdata, rsp_err, $time);
            end
        end
    end

    // ---------------- AHB slave model ----------------
    logic        in_data = 1'b0;
    int          acnt = 0, dcnt = 0;
    logic        cur_w = 1'b0;
    logic [31:0] cur_wd = 32'h0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            in_data = 1'b0; acnt = 0; dcnt = 0; HREADY = 1'b1; HRESP = 1'b0;
        end else if (in_data) begin
            if (dcnt < cfg_dwait) begin
                HREADY = 1'b0;
                HRESP  = cfg_noise || (cfg_err && dcnt == cfg_dwait - 1);
                dcnt++;
            end else begin
                HREADY  = 1'b1;
                HRESP   = cfg_err;
                HRDATA  = cur_w ? 32'hDEAD_BEEF : cfg_rdata;
                in_data = 1'b0;
                if (cur_w) begin
                    checks++;
                    if (HWDATA !== cur_wd) begin
                        errors++;
                        $display("FAIL hwdata: got %h, required %h", HWDATA, cur_wd);
                    end
                end
            end
        end else if (HTRANS == 2'b10) begin
            HRESP = 1'b0;
            if (acnt < cfg_await) begin
                HREADY = 1'b0;
                acnt++;
            end else begin
                HREADY = 1'b1; acnt = 0; in_data = 1'b1; dcnt = 0;
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got NONSEQ addr=%h, required no transfer", HADDR);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    cur_w  = b.write;
                    cur_wd = b.wdata;
                    if (HADDR !== b.addr || HWRITE !== b.write || HSIZE !== b.size) begin
                        errors++;
                        $display("FAIL bus_addr: got addr=%h wr=%0d size=%0d, required addr=%h wr=%0d size=%0d",
                                 HADDR, HWRITE, HSIZE, b.addr, b.write, b.size);
                    end
                end
            end
        end else begin
            HREADY = 1'b1; HRESP = 1'b0; acnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] size, input int lat, input logic [31:0] erd,
                         input logic eerr, input logic bus, input logic rsp, output time acc_t);
        int w;
        exp_t e;
        bus_t b;
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_size = size;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge HCLK);
            w++;
        end
        acc_t = $time;
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept: got cmd_ready=0 after %0d cycles, required 1 (addr=%h)", w, addr);
            cmd_valid = 1'b0;
            return;
        end
        $display("cmd: wr=%0d addr=%h wdata=%h size=%0d accepted at %0t", wr, addr, wd, size, $time);
        if (rsp) begin
            e.rdata = erd; e.err = eerr; e.t = $time + lat * PERIOD;
            exp_q.push_back(e);
        end
        if (bus) begin
            b.addr = addr; b.write = wr; b.size = size; b.wdata = wd;
            bus_q.push_back(b);
        end
        @(posedge HCLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge HCLK);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge HCLK);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else
            $display("%s ok: %h", name, got);
    endtask

    time t1, t2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_size = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_bus", {HADDR, HWDATA}, 64'h0);
        check("reset_ctl", {55'h0, HTRANS, HWRITE, HSIZE, cmd_ready, rsp_valid, rsp_err}, 64'h0);
        check("reset_rdata", {32'h0, rsp_rdata}, 64'h0);
        check("const_ctl", {56'h0, HBURST, HPROT, HMASTLOCK}, {56'h0, 3'b000, 4'b0011, 1'b0});
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("ready_after_reset", {63'h0, cmd_ready}, 64'h1);

        // byte write, zero waits
        issue(1'b1, 32'hC010_0001, 32'h1A, 3'd0, 3, 32'h0, 1'b0, 1'b1, 1'b1, t1);
        drain();

        // halfword read with 2 address and 4 data wait states
        cfg_await = 2; cfg_dwait = 4; cfg_rdata = 32'h01;
        issue(1'b0, 32'hC010_0002, 32'h0, 3'd1, 9, 32'h01, 1'b0, 1'b1, 1'b1, t1);
        drain();
        cfg_await = 0; cfg_dwait = 0;

        // back-to-back write then read
        cfg_rdata = 32'hA5A5_0F0F;
        issue(1'b1, 32'hC010_0004, 32'h1234_5678, 3'd2, 3, 32'h0, 1'b0, 1'b1, 1'b1, t1);
        issue(1'b0, 32'hC010_0008, 32'h0, 3'd2, 3, 32'hA5A5_0F0F, 1'b0, 1'b1, 1'b1, t2);
        check("back_to_back_accept", 64'(t2), 64'(t1 + 3 * PERIOD));
        drain();

        // rejected commands: misaligned word, misaligned halfword, oversize
        issue(1'b1, 32'hC010_0001, 32'h1A, 3'd2, 1, 32'h0, 1'b1, 1'b0, 1'b1, t1);
        drain();
        issue(1'b0, 32'hC010_0003, 32'h0, 3'd1, 1, 32'h0, 1'b1, 1'b0, 1'b1, t1);
        drain();
        issue(1'b0, 32'hC010_0000, 32'h0, 3'd3, 1, 32'h0, 1'b1, 1'b0, 1'b1, t1);
        drain();

        // good read straight into a rejected one accepted during RESP
        cfg_rdata = 32'h7777_0001;
        issue(1'b0, 32'hC010_0010, 32'h0, 3'd2, 3, 32'h7777_0001, 1'b0, 1'b1, 1'b1, t1);
        issue(1'b0, 32'hC010_0012, 32'h0, 3'd2, 1, 32'h0, 1'b1, 1'b0, 1'b1, t2);
        check("b2b_reject_accept", 64'(t2), 64'(t1 + 3 * PERIOD));
        drain();

        // two-cycle ERROR response on a read
        cfg_dwait = 1; cfg_err = 1'b1; cfg_rdata = 32'h0;
        issue(1'b0, 32'hC010_0020, 32'h0, 3'd2, 4, 32'h0, 1'b1, 1'b1, 1'b1, t1);
        drain();
        cfg_err = 1'b0;

        // HRESP noise while HREADY=0 must not produce an error
        cfg_dwait = 3; cfg_noise = 1'b1; cfg_rdata = 32'h5555_AAAA;
        issue(1'b0, 32'hC010_0024, 32'h0, 3'd2, 6, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, t1);
        drain();
        cfg_noise = 1'b0;

        // write with data-phase waits; HWDATA held until HREADY
        cfg_dwait = 2;
        issue(1'b1, 32'hC010_0028, 32'hCAFE_F00D, 3'd2, 5, 32'h0, 1'b0, 1'b1, 1'b1, t1);
        drain();
        cfg_dwait = 0;

        // long address-phase stall: times out with the macro, completes without it
        cfg_await = 40; cfg_rdata = 32'h0BAD_CAFE;
`ifdef AHB_MST_TIMEOUT_EN
        issue(1'b0, 32'hC010_0030, 32'h0, 3'd2, 17, 32'h0, 1'b1, 1'b0, 1'b1, t1);
`else
        issue(1'b0, 32'hC010_0030, 32'h0, 3'd2, 43, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b1, t1);
`endif
        drain();
        cfg_await = 0;

        // reset during the data phase abandons the transfer
        cfg_dwait = 6; cfg_rdata = 32'h1111_2222;
        issue(1'b0, 32'hC010_0040, 32'h0, 3'd2, 0, 32'h0, 1'b0, 1'b1, 1'b0, t1);
        @(negedge HCLK);
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("mid_reset_bus", {HADDR, HWDATA}, 64'h0);
        check("mid_reset_ctl", {58'h0, HTRANS, cmd_ready, rsp_valid, rsp_err}, 64'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("ready_after_mid_reset", {63'h0, cmd_ready}, 64'h1);
        cfg_dwait = 0;
        repeat (8) @(negedge HCLK);

        // recovery read
        cfg_rdata = 32'h0000_00C3;
        issue(1'b0, 32'hC010_0044, 32'h0, 3'd2, 3, 32'h0000_00C3, 1'b0, 1'b1, 1'b1, t1);
        drain();

        check("bus_queue_empty", 64'(bus_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
